// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS datapath register file.
//   reg_idx_t   : register index for the default 32-entry configuration
//   word_t      : data word for the default 32-bit configuration
//   ZERO_IDX    : index of the hardwired zero register
//   is_zero_reg : true when idx addresses the hardwired zero register
package mips_pkg;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] word_t;

  localparam int unsigned ZERO_IDX = 0;

  function automatic logic is_zero_reg(input int unsigned idx, input bit zero_reg);
    return zero_reg && (idx == ZERO_IDX);
  endfunction

endpackage

// File: rtl/pend_tracker.sv
// Pending-write scoreboard for the register file.
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   wr_en      : qualified writeback (in range, not zero reg, not in reset)
//   wa         : writeback address
//   iss_en     : request to mark iss_rd pending
//   iss_rd     : destination being issued
//   iss_ok     : issue accepted this cycle (combinational)
//   pend       : per-register pending bits
//   busy_cnt   : number of pending registers (registered)
module pend_tracker
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wa,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_ok,
  output logic [DEPTH-1:0] pend,
  output logic [AW:0]      busy_cnt
);

  logic iss_in_range;
  logic iss_zero;
  logic pend_eff;
  logic set_en;
  logic clr_en;

  always_comb begin
    iss_in_range = 32'(iss_rd) < DEPTH;
    iss_zero     = is_zero_reg(32'(iss_rd), ZERO_REG);
    pend_eff     = 1'b0;
    // A writeback landing this cycle frees the destination for re-issue.
    if (iss_in_range)
      pend_eff = pend[iss_rd] && !(wr_en && (wa == iss_rd));
    iss_ok = iss_en && !reset && !pend_eff;
    set_en = iss_ok && iss_in_range && !iss_zero;
    clr_en = wr_en && pend[wa];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend     <= '0;
      busy_cnt <= '0;
    end else begin
      // Set is applied after clear so a same-register issue wins.
      if (clr_en) pend[wa]     <= 1'b0;
      if (set_en) pend[iss_rd] <= 1'b1;
      // One set and one clear always net to zero, same register or not.
      if (set_en && !clr_en)
        busy_cnt <= busy_cnt + 1'b1;
      else if (clr_en && !set_en)
        busy_cnt <= busy_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard for the MIPS datapath.
//   clk, reset  : clock (rising edge), asynchronous active-high reset
//   ra1, ra2    : read addresses        rd1, rd2 : read data (combinational)
//   rdy1, rdy2  : no write pending to the addressed register
//   we, wa, wd  : writeback port (clocked)
//   iss_en      : request to mark iss_rd pending
//   iss_rd      : destination being issued
//   iss_ok      : issue accepted this cycle (combinational)
//   busy_cnt    : number of pending registers (registered)
module regfile_sb
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             rdy1,
  output logic             rdy2,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_ok,
  output logic [AW:0]      busy_cnt
);

  logic [WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0] pend;
  logic             wr_en;

  always_comb begin
    wr_en = we && !reset && (32'(wa) < DEPTH) && !is_zero_reg(32'(wa), ZERO_REG);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[wa] <= wd;
    end
  end

  function automatic void read_port(input  logic [AW-1:0]    ra,
                                    output logic [WIDTH-1:0] rd,
                                    output logic             rdy);
    rd  = '0;
    rdy = 1'b1;
    if ((32'(ra) < DEPTH) && !is_zero_reg(32'(ra), ZERO_REG)) begin
      if (BYPASS && wr_en && (wa == ra)) begin
        rd = wd;
      end else begin
        rd  = rf[ra];
        rdy = !pend[ra];
      end
    end
  endfunction

  always_comb read_port(ra1, rd1, rdy1);
  always_comb read_port(ra2, rd2, rdy2);

  pend_tracker #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_pend (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wa       (wa),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .iss_ok   (iss_ok),
    .pend     (pend),
    .busy_cnt (busy_cnt)
  );

endmodule
